// File: rtl/ila_grant_scheduler_if.sv
// Grant/decode/control bundle between the harness, the scheduler and the ILA model.
interface ila_grant_scheduler_if #(
  parameter int NUM_INSTR = 3,
  parameter int BUDGET_W  = 8,
  parameter int CNT_W     = 16
);
  logic                 ila_valid;
  logic [NUM_INSTR-1:0] acc_decode;
  logic [NUM_INSTR-1:0] grant;
  logic [NUM_INSTR-1:0] instr_en;
  logic                 run_req;
  logic                 step_req;
  logic                 halt_req;
  logic                 budget_load;
  logic [BUDGET_W-1:0]  budget_val;
  logic                 err_clr;
  logic [1:0]           state;
  logic                 done;
  logic                 err_multi;
  logic [CNT_W-1:0]     retired_cnt;
  logic [CNT_W-1:0]     stall_cnt;

  modport slave (
    input  ila_valid, acc_decode, instr_en, run_req, step_req, halt_req,
           budget_load, budget_val, err_clr,
    output grant, state, done, err_multi, retired_cnt, stall_cnt
  );

  modport master (
    output ila_valid, acc_decode, instr_en, run_req, step_req, halt_req,
           budget_load, budget_val, err_clr,
    input  grant, state, done, err_multi, retired_cnt, stall_cnt
  );
endinterface

// File: rtl/ila_grant_scheduler.sv
// Drives the one-hot grant of an ILA model under run/step/halt/budget control,
// counts retired and stalled cycles and traps illegal multi-decode.
module ila_grant_scheduler #(
  parameter int NUM_INSTR = 3,
  parameter int BUDGET_W  = 8,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  ila_grant_scheduler_if.slave   bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STEP = 2'b10, FAULT = 2'b11} state_e;

  state_e               state_q, state_d;
  logic [BUDGET_W-1:0]  budget_q, budget_d;
  logic [CNT_W-1:0]     ret_q, ret_d;
  logic [CNT_W-1:0]     stall_q, stall_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;

  logic                 active, multi, issue_ok, fault_ev, retire;
  logic [NUM_INSTR-1:0] grant_w;

  assign active   = (state_q == RUN) || (state_q == STEP);
  // More than one bit set iff clearing the lowest set bit leaves something.
  assign multi    = |(bus.acc_decode & (bus.acc_decode - NUM_INSTR'(1)));
  assign issue_ok = bus.ila_valid & active & ~bus.halt_req & ~multi;
  assign fault_ev = bus.ila_valid & active & multi;

  for (genvar i = 0; i < NUM_INSTR; i++) begin : g_lane
    assign grant_w[i] = issue_ok & bus.acc_decode[i] & bus.instr_en[i];
  end

  assign retire = |grant_w;

  always_comb begin
    state_d  = state_q;
    budget_d = budget_q;
    ret_d    = ret_q;
    stall_d  = stall_q;
    err_d    = err_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.budget_load) budget_d = bus.budget_val;
        if (bus.step_req || bus.run_req) begin
          state_d = bus.step_req ? STEP : RUN;
          ret_d   = '0;
          stall_d = '0;
        end
      end
      RUN, STEP: begin
        // Fault outranks halt, halt outranks retirement.
        if (fault_ev) begin
          state_d = FAULT;
          err_d   = 1'b1;
        end else if (bus.halt_req) begin
          state_d = IDLE;
        end else if (retire) begin
          ret_d = ret_q + CNT_W'(1);
          if (state_q == STEP) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (budget_q != '0) begin
            budget_d = budget_q - BUDGET_W'(1);
            if (budget_q == BUDGET_W'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end else if (!(&stall_q)) begin
          stall_d = stall_q + CNT_W'(1);
        end
      end
      FAULT: begin
        if (bus.err_clr) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      budget_q <= '0;
      ret_q    <= '0;
      stall_q  <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      budget_q <= budget_d;
      ret_q    <= ret_d;
      stall_q  <= stall_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign bus.grant       = grant_w;
  assign bus.state       = state_q;
  assign bus.done        = done_q;
  assign bus.err_multi   = err_q;
  assign bus.retired_cnt = ret_q;
  assign bus.stall_cnt   = stall_q;
endmodule

// File: tb/tb_ila_grant_scheduler.sv
// Vector table plus scoreboard queue for the grant scheduler; async reset hand sequence at the end.
module tb_ila_grant_scheduler;
  localparam int NI = 3, BW = 8, CW = 16;
  localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_STEP = 2'b10, S_FAULT = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ila_grant_scheduler_if #(.NUM_INSTR(NI), .BUDGET_W(BW), .CNT_W(CW)) bus ();

  ila_grant_scheduler #(.NUM_INSTR(NI), .BUDGET_W(BW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic          vl;
    logic [NI-1:0] dec, en;
    logic          run, stp, hlt, bl;
    logic [BW-1:0] bv;
    logic          clr;
    logic [NI-1:0] e_grant;
    logic [1:0]    e_state;
    logic          e_done, e_err;
    logic [CW-1:0] e_ret, e_stall;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic vl, logic [NI-1:0] dec, logic [NI-1:0] en,
                              logic run, logic stp, logic hlt, logic bl, logic [BW-1:0] bv,
                              logic clr, logic [NI-1:0] eg, logic [1:0] es, logic ed,
                              logic ee, logic [CW-1:0] er, logic [CW-1:0] est);
    vec_t v;
    v.vl = vl; v.dec = dec; v.en = en; v.run = run; v.stp = stp; v.hlt = hlt;
    v.bl = bl; v.bv = bv; v.clr = clr; v.e_grant = eg; v.e_state = es;
    v.e_done = ed; v.e_err = ee; v.e_ret = er; v.e_stall = est;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.ila_valid   = v.vl;
    bus.acc_decode  = v.dec;
    bus.instr_en    = v.en;
    bus.run_req     = v.run;
    bus.step_req    = v.stp;
    bus.halt_req    = v.hlt;
    bus.budget_load = v.bl;
    bus.budget_val  = v.bv;
    bus.err_clr     = v.clr;
  endtask

  // Called at posedge+1: drive, check grant mid-cycle, check registered outputs after the edge.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    drive(v);
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    chk($sformatf("v%0d grant", idx), 32'(bus.grant), 32'(e.e_grant));
    @(posedge clk); #1;
    chk($sformatf("v%0d state", idx), 32'(bus.state), 32'(e.e_state));
    chk($sformatf("v%0d done", idx), 32'(bus.done), 32'(e.e_done));
    chk($sformatf("v%0d err", idx), 32'(bus.err_multi), 32'(e.e_err));
    chk($sformatf("v%0d retired", idx), 32'(bus.retired_cnt), 32'(e.e_ret));
    chk($sformatf("v%0d stall", idx), 32'(bus.stall_cnt), 32'(e.e_stall));
  endtask

  initial begin
    //                 vl dec     en      run  stp  hlt  bl   bv  clr  grant   state    dn er ret stl
    // budget 3, free run, three retires then exhaustion
    tbl.push_back(mk(1, 3'b001, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b0, 3'b000, S_RUN,   0, 0, 0, 0));
    tbl.push_back(mk(1, 3'b001, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3'b001, S_RUN,   0, 0, 1, 0));
    tbl.push_back(mk(1, 3'b001, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3'b001, S_RUN,   0, 0, 2, 0));
    tbl.push_back(mk(1, 3'b001, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3'b001, S_IDLE,  1, 0, 3, 0));
    tbl.push_back(mk(1, 3'b001, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3'b000, S_IDLE,  0, 0, 3, 0));
    // single step with two empty cycles
    tbl.push_back(mk(1, 3'b000, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 3'b000, S_STEP,  0, 0, 0, 0));
    tbl.push_back(mk(1, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3'b000, S_STEP,  0, 0, 0, 1));
    tbl.push_back(mk(1, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3'b000, S_STEP,  0, 0, 0, 2));
    tbl.push_back(mk(1, 3'b010, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3'b010, S_IDLE,  1, 0, 1, 2));
    tbl.push_back(mk(1, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3'b000, S_IDLE,  0, 0, 1, 2));
    // unlimited run with the decoded instruction masked off
    tbl.push_back(mk(1, 3'b100, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3'b000, S_RUN,   0, 0, 0, 0));
    tbl.push_back(mk(1, 3'b100, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3'b000, S_RUN,   0, 0, 0, 1));
    tbl.push_back(mk(1, 3'b100, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3'b000, S_RUN,   0, 0, 0, 2));
    tbl.push_back(mk(1, 3'b100, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3'b000, S_RUN,   0, 0, 0, 3));
    tbl.push_back(mk(1, 3'b100, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3'b000, S_RUN,   0, 0, 0, 4));
    // multi-decode fault, requests ignored, clear
    tbl.push_back(mk(1, 3'b011, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3'b000, S_FAULT, 0, 1, 0, 4));
    tbl.push_back(mk(1, 3'b001, 3'b111, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b0, 3'b000, S_FAULT, 0, 1, 0, 4));
    tbl.push_back(mk(1, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 3'b000, S_IDLE,  0, 0, 0, 4));
    // budget 1, halt on the would-be retire, budget survives and exhausts later
    tbl.push_back(mk(1, 3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0, 3'b000, S_RUN,   0, 0, 0, 0));
    tbl.push_back(mk(1, 3'b001, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 3'b000, S_IDLE,  0, 0, 0, 0));
    tbl.push_back(mk(1, 3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3'b000, S_RUN,   0, 0, 0, 0));
    tbl.push_back(mk(1, 3'b001, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3'b001, S_IDLE,  1, 0, 1, 0));
    // halt and multi-decode together: fault wins
    tbl.push_back(mk(1, 3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3'b000, S_RUN,   0, 0, 0, 0));
    tbl.push_back(mk(1, 3'b110, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 3'b000, S_FAULT, 0, 1, 0, 0));
    tbl.push_back(mk(1, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 3'b000, S_IDLE,  0, 0, 0, 0));
    // invalid cycle stalls; budget_load while running is ignored
    tbl.push_back(mk(1, 3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3'b000, S_RUN,   0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b001, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3'b000, S_RUN,   0, 0, 0, 1));
    tbl.push_back(mk(1, 3'b001, 3'b111, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0, 3'b000, S_IDLE,  0, 0, 0, 1));
    // step beats run
    tbl.push_back(mk(1, 3'b000, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 3'b000, S_STEP,  0, 0, 0, 0));
    tbl.push_back(mk(1, 3'b000, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 3'b000, S_IDLE,  0, 0, 0, 0));

    drive(mk(0, 3'b000, 3'b111, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst state", 32'(bus.state), 32'(S_IDLE));
    chk("rst done", 32'(bus.done), 0);
    chk("rst err", 32'(bus.err_multi), 0);
    chk("rst retired", 32'(bus.retired_cnt), 0);
    chk("rst stall", 32'(bus.stall_cnt), 0);
    chk("rst grant", 32'(bus.grant), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Five retires in unlimited run (budget is 0), then async reset mid-cycle.
    drive(mk(1, 3'b001, 3'b111, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    bus.run_req = 1'b0;
    chk("t6 start state", 32'(bus.state), 32'(S_RUN));
    repeat (5) @(posedge clk);
    #1;
    chk("t6 retired5", 32'(bus.retired_cnt), 5);
    chk("t6 still run", 32'(bus.state), 32'(S_RUN));
    chk("t6 grant live", 32'(bus.grant), 32'(3'b001));
    #2;
    bus.run_req = 1'b1;
    rst = 1'b0;
    #1;
    chk("t6 async state", 32'(bus.state), 32'(S_IDLE));
    chk("t6 async grant", 32'(bus.grant), 0);
    chk("t6 async retired", 32'(bus.retired_cnt), 0);
    chk("t6 async stall", 32'(bus.stall_cnt), 0);
    bus.run_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t6 no issue", 32'(bus.grant), 0);
    chk("t6 idle hold", 32'(bus.state), 32'(S_IDLE));
    @(posedge clk); #1;
    bus.run_req = 1'b1;
    @(posedge clk); #1;
    bus.run_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t6 restart retired", 32'(bus.retired_cnt), 2);
    chk("t6 restart state", 32'(bus.state), 32'(S_RUN));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
